// File: rtl/uart_fifo_arbiter_pkg.sv
// Shared definitions for the UART FIFO arbiter: FSM state encoding and default sizing.
package uart_fifo_arbiter_pkg;

    localparam int DEF_NUM_REQ   = 4;
    localparam int DEF_FIFO_SIZE = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT  = 2'd1,
        ST_XFER   = 2'd2,
        ST_FINISH = 2'd3
    } state_t;

endpackage

// File: rtl/uart_fifo_arbiter_rr_pick.sv
// Round-robin priority encoder: lowest requester at or above i_ptr wins, else wraps to lowest overall.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [PTR_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic               o_vld
);

    logic [NUM_REQ-1:0] w_masked;

    always_comb begin
        w_masked = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_masked[i] = i_req[i] && (i >= int'(i_ptr));
        end
        // Downward scans so the lowest set index is written last; masked hits override the wrap pick.
        o_gnt = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_gnt    = '0;
                o_gnt[i] = 1'b1;
            end
        end
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (w_masked[i]) begin
                o_gnt    = '0;
                o_gnt[i] = 1'b1;
            end
        end
    end

    assign o_vld = |i_req;

endmodule

// File: rtl/uart_fifo_arbiter.sv
// Round-robin arbiter granting one requester at a time to a frame-based UART FIFO.
// Optional watchdog enabled by defining UART_ARB_TIMEOUT_EN.
module uart_fifo_arbiter
    import uart_fifo_arbiter_pkg::*;
#(
    parameter int NUM_REQ     = DEF_NUM_REQ,
    parameter int FIFO_SIZE   = DEF_FIFO_SIZE,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic                           CLK,
    input  logic                           RST,
    input  logic [NUM_REQ-1:0]             REQ,
    input  logic [NUM_REQ*8*FIFO_SIZE-1:0] REQ_DATA,
    output logic [NUM_REQ-1:0]             GNT,
    output logic [NUM_REQ-1:0]             DONE,
    output logic [8*FIFO_SIZE-1:0]         RSP_DATA,
    output logic [8*FIFO_SIZE-1:0]         FIFO_DIN,
    input  logic [8*FIFO_SIZE-1:0]         FIFO_DOUT,
    input  logic                           FIFO_RDY,
    output logic                           BUSY,
    output logic                           TIMEOUT
);

    localparam int FW = 8 * FIFO_SIZE;
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_t             r_state;
    logic [PW-1:0]      r_ptr;
    logic [PW-1:0]      r_win;
    logic [NUM_REQ-1:0] r_gnt;
    logic [NUM_REQ-1:0] r_done;
    logic [FW-1:0]      r_din;
    logic [FW-1:0]      r_rsp;

    logic [NUM_REQ-1:0] w_pick;
    logic               w_vld;
    logic [PW-1:0]      w_pick_idx;
    logic [FW-1:0]      w_slice;
    logic [PW-1:0]      w_win_next;
    logic               w_tmo;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PW)
    ) u_rr_pick (
        .i_req (REQ),
        .i_ptr (r_ptr),
        .o_gnt (w_pick),
        .o_vld (w_vld)
    );

    always_comb begin
        w_pick_idx = '0;
        w_slice    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_pick[i]) begin
                w_pick_idx = PW'(i);
                w_slice    = REQ_DATA[i*FW +: FW];
            end
        end
    end

    assign w_win_next = (r_win == PW'(NUM_REQ - 1)) ? '0 : r_win + 1'b1;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic [TW-1:0] r_tcnt;
    logic          r_timeout;

    // Counter restarts at zero on every entry to GRANT; the flag is sticky until reset.
    assign w_tmo = (r_state == ST_GRANT || r_state == ST_XFER) &&
                   (r_tcnt == TW'(TIMEOUT_CYC - 1));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_tcnt    <= '0;
            r_timeout <= 1'b0;
        end else begin
            if (r_state == ST_GRANT || r_state == ST_XFER) begin
                r_tcnt <= r_tcnt + 1'b1;
            end else begin
                r_tcnt <= '0;
            end
            if (w_tmo) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign TIMEOUT = r_timeout;
`else
    assign w_tmo   = 1'b0;
    assign TIMEOUT = 1'b0;
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
            r_win   <= '0;
            r_gnt   <= '0;
            r_done  <= '0;
            r_din   <= '0;
            r_rsp   <= '0;
        end else begin
            r_done <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_vld && FIFO_RDY) begin
                        r_gnt   <= w_pick;
                        r_win   <= w_pick_idx;
                        r_din   <= w_slice;
                        r_state <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    // A withdrawn request abandons the grant without touching the pointer.
                    if ((REQ & r_gnt) == '0) begin
                        r_gnt   <= '0;
                        r_state <= ST_IDLE;
                    end else if (w_tmo) begin
                        r_gnt   <= '0;
                        r_ptr   <= w_win_next;
                        r_state <= ST_IDLE;
                    end else if (!FIFO_RDY) begin
                        r_state <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    if (FIFO_RDY) begin
                        r_rsp   <= FIFO_DOUT;
                        r_done  <= r_gnt;
                        r_gnt   <= '0;
                        r_ptr   <= w_win_next;
                        r_state <= ST_FINISH;
                    end else if (w_tmo) begin
                        r_gnt   <= '0;
                        r_ptr   <= w_win_next;
                        r_state <= ST_IDLE;
                    end
                end
                ST_FINISH: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign GNT      = r_gnt;
    assign DONE     = r_done;
    assign FIFO_DIN = r_din;
    assign RSP_DATA = r_rsp;
    assign BUSY     = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_fifo_arbiter.sv
// Directed self-checking bench for uart_fifo_arbiter (4 requesters, 4-byte frames).
module tb_uart_fifo_arbiter;

    localparam int NUM_REQ   = 4;
    localparam int FIFO_SIZE = 4;
    localparam int FW        = 8 * FIFO_SIZE;

    logic                      CLK;
    logic                      RST;
    logic [NUM_REQ-1:0]        REQ;
    logic [NUM_REQ*FW-1:0]     REQ_DATA;
    logic [NUM_REQ-1:0]        GNT;
    logic [NUM_REQ-1:0]        DONE;
    logic [FW-1:0]             RSP_DATA;
    logic [FW-1:0]             FIFO_DIN;
    logic [FW-1:0]             FIFO_DOUT;
    logic                      FIFO_RDY;
    logic                      BUSY;
    logic                      TIMEOUT;

    int n_vec;
    int n_err;

    uart_fifo_arbiter #(
        .NUM_REQ     (NUM_REQ),
        .FIFO_SIZE   (FIFO_SIZE),
        .TIMEOUT_CYC (16)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .REQ       (REQ),
        .REQ_DATA  (REQ_DATA),
        .GNT       (GNT),
        .DONE      (DONE),
        .RSP_DATA  (RSP_DATA),
        .FIFO_DIN  (FIFO_DIN),
        .FIFO_DOUT (FIFO_DOUT),
        .FIFO_RDY  (FIFO_RDY),
        .BUSY      (BUSY),
        .TIMEOUT   (TIMEOUT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // One full transfer with all pending requests held; expects requester idx to win.
    task automatic xfer(input int idx);
        int n;
        n = 0;
        while (GNT == '0 && n < 5) begin
            tick();
            n++;
        end
        chk("rr_gnt", 32'(GNT), 32'(1) << idx);
        FIFO_RDY = 1'b0;
        tick();
        FIFO_RDY = 1'b1;
        tick();
        chk("rr_done", 32'(DONE), 32'(1) << idx);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        n_vec     = 0;
        n_err     = 0;
        RST       = 1'b1;
        REQ       = '0;
        REQ_DATA  = {32'hA3A3_0003, 32'hA2A2_0002, 32'hA1A1_0001, 32'hA0A0_0000};
        FIFO_DOUT = '0;
        FIFO_RDY  = 1'b1;

        #1;
        chk("rst_gnt",  32'(GNT), 32'h0);
        chk("rst_done", 32'(DONE), 32'h0);
        chk("rst_busy", 32'(BUSY), 32'h0);
        chk("rst_tmo",  32'(TIMEOUT), 32'h0);
        chk("rst_din",  FIFO_DIN, 32'h0);
        chk("rst_rsp",  RSP_DATA, 32'h0);
        tick();
        RST = 1'b0;
        tick();
        chk("idle_gnt", 32'(GNT), 32'h0);

        // Single request; REQ dropped mid-XFER must not cancel the transfer.
        REQ = 4'b0001;
        tick();
        chk("single_gnt",  32'(GNT), 32'h1);
        chk("single_din",  FIFO_DIN, 32'hA0A0_0000);
        chk("single_busy", 32'(BUSY), 32'h1);
        FIFO_RDY  = 1'b0;
        FIFO_DOUT = 32'hDEAD_BEEF;
        tick();
        REQ = 4'b0000;
        repeat (7) tick();
        chk("xfer_gnt_hold", 32'(GNT), 32'h1);
        chk("xfer_rsp_hold", RSP_DATA, 32'h0);
        FIFO_RDY = 1'b1;
        tick();
        chk("single_done",   32'(DONE), 32'h1);
        chk("single_gntclr", 32'(GNT), 32'h0);
        chk("single_rsp",    RSP_DATA, 32'hDEAD_BEEF);
        tick();
        chk("done_pulse",  32'(DONE), 32'h0);
        chk("idle_busy",   32'(BUSY), 32'h0);
        chk("din_hold",    FIFO_DIN, 32'hA0A0_0000);

        // FIFO busy blocks arbitration until it reports idle.
        FIFO_RDY = 1'b0;
        REQ      = 4'b0010;
        repeat (3) tick();
        chk("busy_nogrant", 32'(GNT), 32'h0);
        FIFO_RDY = 1'b1;
        tick();
        chk("busy_gnt", 32'(GNT), 32'h2);
        chk("busy_din", FIFO_DIN, 32'hA1A1_0001);
        FIFO_RDY  = 1'b0;
        FIFO_DOUT = 32'h1234_5678;
        tick();
        FIFO_RDY = 1'b1;
        tick();
        chk("busy_done", 32'(DONE), 32'h2);
        chk("busy_rsp",  RSP_DATA, 32'h1234_5678);
        REQ = 4'b0000;
        tick();

        // Withdraw in GRANT: no DONE, pointer stays at 2.
        REQ = 4'b0100;
        tick();
        chk("wd_gnt", 32'(GNT), 32'h4);
        REQ = 4'b0000;
        tick();
        chk("wd_gntclr", 32'(GNT), 32'h0);
        chk("wd_done",   32'(DONE), 32'h0);
        chk("wd_busy",   32'(BUSY), 32'h0);
        chk("wd_rsp",    RSP_DATA, 32'h1234_5678);
        REQ = 4'b1111;
        tick();
        chk("wd_ptr", 32'(GNT), 32'h4);
        REQ = 4'b0000;
        tick();

        // Grant held with FIFO_RDY high: watchdog fires, or grant persists without it.
        REQ = 4'b1000;
        tick();
        chk("tmo_gnt", 32'(GNT), 32'h8);
`ifdef UART_ARB_TIMEOUT_EN
        repeat (15) tick();
        chk("tmo_early", 32'(TIMEOUT), 32'h0);
        tick();
        chk("tmo_flag", 32'(TIMEOUT), 32'h1);
        chk("tmo_gnt0", 32'(GNT), 32'h0);
        chk("tmo_done", 32'(DONE), 32'h0);
`else
        repeat (20) tick();
        chk("notmo_gnt",  32'(GNT), 32'h8);
        chk("notmo_flag", 32'(TIMEOUT), 32'h0);
`endif
        REQ = 4'b0000;
        tick();

        // Asynchronous reset in the middle of XFER.
        REQ = 4'b0001;
        tick();
        FIFO_RDY = 1'b0;
        tick();
        chk("mid_busy", 32'(BUSY), 32'h1);
        #2;
        RST = 1'b1;
        #1;
        chk("arst_gnt",  32'(GNT), 32'h0);
        chk("arst_busy", 32'(BUSY), 32'h0);
        chk("arst_din",  FIFO_DIN, 32'h0);
        chk("arst_rsp",  RSP_DATA, 32'h0);
        chk("arst_done", 32'(DONE), 32'h0);
        chk("arst_tmo",  32'(TIMEOUT), 32'h0);
        REQ      = 4'b0000;
        FIFO_RDY = 1'b1;
        tick();
        RST = 1'b0;
        tick();
        chk("arst_nodone", 32'(DONE), 32'h0);
        chk("arst_idle",   32'(GNT), 32'h0);

        // Fairness with all four requesting, then back-to-back single requester.
        REQ = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            xfer(i % NUM_REQ);
        end
        REQ = 4'b0001;
        xfer(0);
        xfer(0);
        REQ = 4'b0000;
        tick();
        chk("end_idle", 32'(BUSY), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
